multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multicycle main control FSM for the RISC-16 core. It sequences every instruction through fetch, decode, execute, memory and writeback, and generates the datapath strobes. It drives the 2-bit `alu_op` consumed by the ALU control unit, which maps it to a 3-bit ALU function. It also handles memory wait states through a ready handshake and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `opcode`  in  4: instruction register bits [15:12]. Valid only in DECODE.
- `mem_ready`  in  1: memory acknowledges the current read/write this cycle.
- `zero`  in  1: ALU zero flag. Valid in EXEC.
- `state`  out  3: current state (debug).
- `alu_op`  out  2: to the ALU control unit. 00 = R-type (function from opcode), 10 = add (address), 01 = subtract (compare).
- `alu_src`  out  1: 1 = sign-extended immediate, 0 = register.
- `reg_dst`  out  1: 1 = rd, 0 = rt.
- `mem_to_reg`  out  1: writeback source is memory.
- `reg_write`, `mem_read`, `mem_write`, `ir_write`, `pc_write`, `jump`  out  1 each: datapath strobes.
- `instr_done`  out  1: one-cycle pulse in the final cycle of each legal instruction.
- `illegal`  out  1: one-cycle pulse for an undefined opcode.
- `instr_count`  out  CNT_W: retired legal instructions.

## Operation
- Reset: synchronous and active-high. On a rising edge with `reset`=1, `state` goes to FETCH, `op_q` goes to 0 and `instr_count` goes to 0.
- While `reset`=1, every strobe output is forced to 0, including `mem_read`, and `alu_op` is 00.
- A reset asserted mid-instruction aborts that instruction. No write strobe fires on that edge.
- Opcode classes:
  - LW = 0000, SW = 0001.
  - R-type = 0010–1001.
  - BEQ = 1011, BNE = 1100, JMP = 1101.
  - Illegal = 1010, 1110, 1111.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 go to FETCH on the next edge.
- FETCH:
  - `mem_read`=1 in every cycle of this state.
  - Stay in FETCH while `mem_ready`=0.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 (PC+2), next state DECODE.
- DECODE:
  - `op_q` is loaded with `opcode` on the exiting edge.
  - Illegal opcode: `illegal`=1, next state FETCH, counter unchanged.
  - Otherwise next state EXEC.
- EXEC (all decoded from `op_q`):
  - R-type: `alu_op`=00, `alu_src`=0, next state WB.
  - LW or SW: `alu_op`=10, `alu_src`=1, next state MEM.
  - BEQ: `alu_op`=01, `alu_src`=0, `pc_write`=`zero`. Then `instr_done`=1, next state FETCH.
  - BNE: same as BEQ except `pc_write`=~`zero`.
  - JMP: `jump`=1, `pc_write`=1, `instr_done`=1, next state FETCH.
- MEM:
  - `alu_op`=10 and `alu_src`=1 are held throughout.
  - LW: `mem_read`=1 until `mem_ready`, then next state WB.
  - SW: `mem_write`=1 until `mem_ready`. In the `mem_ready` cycle `instr_done`=1, then next state FETCH.
- WB:
  - `reg_write`=1.
  - `mem_to_reg`=1 for LW; for R-type, `mem_to_reg`=0 and `reg_dst`=1.
  - `instr_done`=1, next state FETCH.
- Counter: `instr_count` increments by 1 on every edge where `instr_done`=1. It wraps modulo 2^CNT_W.
- Default: any output not listed for a state is 0.

## Timing
- All outputs are combinational decodes of the registered `state` and `op_q`, qualified by `mem_ready`, `zero` and `reset` as described in Operation. There are no combinational paths from `opcode` except the DECODE `illegal` pulse.
- Zero-wait memory latency, in cycles:
  - R-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, BNE, JMP: 3.
  - Illegal: 2.
- Each cycle with `mem_ready`=0 while in FETCH or MEM adds one cycle.
- A `mem_ready` pulse outside FETCH or MEM is ignored.
- `zero` is sampled only in EXEC for BEQ and BNE.
- `illegal` and `instr_done` are never high in the same cycle.
- At most one of `mem_read` and `mem_write` is high in any cycle.

## Test plan
- **Reset:** reset held 2 cycles, then released. Required: state=0, `instr_count`=0, all strobes 0 during reset, `mem_read`=1 in the first cycle after release.
- **R-type and LW, zero-wait:** `opcode`=0010 with `mem_ready`=1 always, then `opcode`=0000. Required: state sequence 0,1,2,4 with `alu_op`=00 in EXEC and `reg_write`=1 in WB. Then sequence 0,1,2,3,4 with `alu_op`=10 and `mem_to_reg`=1. `instr_count`=2.
- **SW with wait states:** `opcode`=0001, `mem_ready` low for 3 cycles in MEM. Required: `mem_write` high for 4 cycles, `instr_done` in the 4th, `reg_write` never asserted.
- **Branches:** BEQ with `zero`=1 gives `pc_write`=1 in EXEC; BEQ with `zero`=0 gives `pc_write`=0; BNE with `zero`=0 gives `pc_write`=1. Each returns to FETCH in 3 cycles.
- **Illegal opcode:** `opcode`=1110. Required: `illegal` pulses in DECODE, next state FETCH, `instr_count` unchanged.
- **Reset mid-LW and counter wrap:** assert reset in MEM. Required: FETCH next, no `reg_write`. With CNT_W=4, retire 17 instructions. Required: `instr_count`=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle main control FSM sequencing fetch/decode/exec/mem/wb with a retired-instruction counter
module multicycle_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic [2:0]       state,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             jump,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;
  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_lw, is_sw, is_r, is_beq, is_bne, is_jmp, is_mem, dec_illegal;
  assign is_lw       = op_q == 4'd0;
  assign is_sw       = op_q == 4'd1;
  assign is_r        = op_q >= 4'd2 && op_q <= 4'd9;
  assign is_beq      = op_q == 4'd11;
  assign is_bne      = op_q == 4'd12;
  assign is_jmp      = op_q == 4'd13;
  assign is_mem      = is_lw || is_sw;
  assign dec_illegal = opcode == 4'd10 || opcode >= 4'd14;
  assign state       = state_q;
  assign instr_count = cnt_q;
  // next state, opcode capture and strobe decode; reset masks every strobe
  always_comb begin
    state_d    = FETCH;
    op_d       = op_q;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d  = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        op_d    = opcode;
        illegal = dec_illegal;
        state_d = dec_illegal ? FETCH : EXEC;
      end
      EXEC: begin
        alu_op     = is_mem ? 2'b10 : (is_beq || is_bne) ? 2'b01 : 2'b00;
        alu_src    = is_mem;
        pc_write   = (is_beq && zero) || (is_bne && !zero) || is_jmp;
        jump       = is_jmp;
        instr_done = is_beq || is_bne || is_jmp;
        state_d    = is_r ? WB : is_mem ? MEM : FETCH;
      end
      MEM: begin
        alu_op     = 2'b10;
        alu_src    = 1'b1;
        mem_read   = is_lw;
        mem_write  = is_sw;
        instr_done = is_sw && mem_ready;
        state_d    = (is_mem && !mem_ready) ? MEM : is_lw ? WB : FETCH;
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        reg_dst    = is_r;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    if (reset) begin
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      jump       = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(instr_done);
  end
  // state, latched opcode and retired counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized self-checking bench against an instruction-level model
module tb_multicycle_control_unit;
  logic        clk = 1'b0;
  logic        reset, mem_ready, zero;
  logic [3:0]  opcode;
  logic [2:0]  state, state4;
  logic [1:0]  alu_op, alu_op4;
  logic        alu_src, reg_dst, mem_to_reg, reg_write, mem_read, mem_write, ir_write, pc_write, jump, instr_done, illegal;
  logic        alu_src4, reg_dst4, mem_to_reg4, reg_write4, mem_read4, mem_write4, ir_write4, pc_write4, jump4, instr_done4, illegal4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;
  int          total = 0;
  int          bad = 0;
  int          model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .state(state), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .jump(jump), .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .state(state4), .alu_op(alu_op4), .alu_src(alu_src4), .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4),
    .reg_write(reg_write4), .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
    .pc_write(pc_write4), .jump(jump4), .instr_done(instr_done4), .illegal(illegal4), .instr_count(instr_count4)
  );

  // 0=R 1=LW 2=SW 3=BEQ 4=BNE 5=JMP 6=illegal
  function automatic int kind(input logic [3:0] op);
    return op == 0 ? 1 : op == 1 ? 2 : op <= 9 ? 0 : op == 11 ? 3 : op == 12 ? 4 : op == 13 ? 5 : 6;
  endfunction

  function automatic logic [3:0] rand_legal();
    logic [3:0] op;
    do op = 4'($urandom_range(0, 15)); while (kind(op) == 6);
    return op;
  endfunction

  task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    int k, exp_alu, exp_pc, n_rw, n_mw, n_mr, n_done, n_ill, n_pcw, n_ir;
    logic [2:0] sq[$];
    logic rq[$];
    k = kind(op);
    exp_alu = (k == 1 || k == 2) ? 2 : (k == 3 || k == 4) ? 1 : 0;
    exp_pc = k == 3 ? int'(z) : k == 4 ? int'(!z) : k == 5 ? 1 : 0;
    n_rw = 0; n_mw = 0; n_mr = 0; n_done = 0; n_ill = 0; n_pcw = 0; n_ir = 0;
    repeat (fw) begin sq.push_back(3'd0); rq.push_back(1'b0); end
    sq.push_back(3'd0); rq.push_back(1'b1);
    sq.push_back(3'd1); rq.push_back(1'($urandom));
    if (k != 6) begin sq.push_back(3'd2); rq.push_back(1'($urandom)); end
    if (k == 1 || k == 2) begin
      repeat (mw) begin sq.push_back(3'd3); rq.push_back(1'b0); end
      sq.push_back(3'd3); rq.push_back(1'b1);
    end
    if (k == 0 || k == 1) begin sq.push_back(3'd4); rq.push_back(1'($urandom)); end
    for (int i = 0; i < sq.size(); i++) begin
      reset = 1'b0;
      mem_ready = rq[i];
      opcode = sq[i] == 3'd1 ? op : 4'($urandom);
      zero = sq[i] == 3'd2 ? z : 1'($urandom);
      @(negedge clk);
      total++;
      if (state !== sq[i]) begin bad++; $display("FAIL state op=%0d cyc=%0d: got %0d want %0d", op, i, state, sq[i]); end
      total++;
      if ((instr_done && illegal) || (mem_read && mem_write)) begin
        bad++; $display("FAIL exclusive op=%0d cyc=%0d: done=%b ill=%b mr=%b mw=%b want no overlap", op, i, instr_done, illegal, mem_read, mem_write);
      end
      if (sq[i] == 3'd2) begin
        total++;
        if (alu_op !== 2'(exp_alu)) begin bad++; $display("FAIL exec_alu_op op=%0d: got %b want %0d", op, alu_op, exp_alu); end
        total++;
        if (jump !== (k == 5) || alu_src !== (k == 1 || k == 2)) begin
          bad++; $display("FAIL exec_jump_src op=%0d: got jump=%b src=%b", op, jump, alu_src);
        end
      end
      if (sq[i] == 3'd4) begin
        total++;
        if (mem_to_reg !== (k == 1) || reg_dst !== (k == 0)) begin
          bad++; $display("FAIL wb_mux op=%0d: got m2r=%b rd=%b want m2r=%b rd=%b", op, mem_to_reg, reg_dst, k == 1, k == 0);
        end
      end
      n_rw += int'(reg_write); n_mw += int'(mem_write); n_mr += int'(mem_read);
      n_done += int'(instr_done); n_ill += int'(illegal); n_pcw += int'(pc_write); n_ir += int'(ir_write);
      @(posedge clk); #1;
    end
    if (k != 6) model_cnt++;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL end_state op=%0d: got %0d want 0", op, state); end
    total++;
    if (n_rw !== ((k <= 1) ? 1 : 0)) begin bad++; $display("FAIL reg_write_cycles op=%0d: got %0d", op, n_rw); end
    total++;
    if (n_mw !== (k == 2 ? mw + 1 : 0)) begin bad++; $display("FAIL mem_write_cycles op=%0d: got %0d want %0d", op, n_mw, k == 2 ? mw + 1 : 0); end
    total++;
    if (n_mr !== fw + 1 + (k == 1 ? mw + 1 : 0)) begin bad++; $display("FAIL mem_read_cycles op=%0d: got %0d", op, n_mr); end
    total++;
    if (n_done !== (k != 6 ? 1 : 0) || n_ill !== (k == 6 ? 1 : 0)) begin
      bad++; $display("FAIL done_illegal op=%0d: got done=%0d ill=%0d", op, n_done, n_ill);
    end
    total++;
    if (n_pcw !== 1 + exp_pc || n_ir !== 1) begin bad++; $display("FAIL pc_ir_write op=%0d: got pcw=%0d ir=%0d want pcw=%0d", op, n_pcw, n_ir, 1 + exp_pc); end
    total++;
    if (instr_count !== 16'(model_cnt) || instr_count4 !== 4'(model_cnt)) begin
      bad++; $display("FAIL count op=%0d: got %0d/%0d want %0d", op, instr_count, instr_count4, model_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'($urandom); zero = 1'($urandom); opcode = 4'($urandom);
    @(posedge clk); #1;
    repeat (2) begin
      mem_ready = 1'($urandom); opcode = 4'($urandom);
      @(negedge clk);
      total++;
      if ({reg_write, mem_read, mem_write, ir_write, pc_write, jump, instr_done, illegal, alu_src, reg_dst, mem_to_reg, alu_op} !== 13'd0 || state !== 3'd0) begin
        bad++; $display("FAIL reset_strobes: got state=%0d mr=%b alu_op=%b want all 0", state, mem_read, alu_op);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || instr_count !== 16'd0 || instr_count4 !== 4'd0 || mem_read !== 1'b1) begin
      bad++; $display("FAIL after_reset: got state=%0d cnt=%0d mr=%b want 0 0 1", state, instr_count, mem_read);
    end
    @(posedge clk); #1;
    model_cnt = 0;
  endtask

  task automatic test_rtype_lw();
    run_instr(4'b0010, 1'b0, 0, 0);
    run_instr(4'b0000, 1'b0, 0, 0);
    total++;
    if (instr_count !== 16'd2) begin bad++; $display("FAIL rtype_lw_count: got %0d want 2", instr_count); end
  endtask

  task automatic test_sw_wait();
    run_instr(4'b0001, 1'b0, 0, 3);
  endtask

  task automatic test_branches();
    run_instr(4'b1011, 1'b1, 0, 0);
    run_instr(4'b1011, 1'b0, 0, 0);
    run_instr(4'b1100, 1'b0, 0, 0);
    run_instr(4'b1100, 1'b1, 1, 0);
    run_instr(4'b1101, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr(4'b1110, 1'b0, 0, 0);
    run_instr(4'b1010, 1'b0, 0, 0);
    run_instr(4'b1111, 1'b0, 2, 0);
  endtask

  task automatic test_mid_reset();
    reset = 1'b0; zero = 1'b0;
    mem_ready = 1'b1; opcode = 4'($urandom); @(posedge clk); #1;
    mem_ready = 1'b0; opcode = 4'b0000;      @(posedge clk); #1;
    opcode = 4'($urandom);                   @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (state !== 3'd3 || {reg_write, mem_read, mem_write, instr_done, alu_op} !== 5'd0) begin
      bad++; $display("FAIL mid_reset_mem: got state=%0d rw=%b mr=%b done=%b alu_op=%b want 3 and strobes 0", state, reg_write, mem_read, instr_done, alu_op);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || reg_write !== 1'b0 || instr_count !== 16'd0) begin
      bad++; $display("FAIL mid_reset_after: got state=%0d rw=%b cnt=%0d want 0 0 0", state, reg_write, instr_count);
    end
    @(posedge clk); #1;
    model_cnt = 0;
  endtask

  task automatic test_wrap();
    test_reset();
    repeat (17) run_instr(rand_legal(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    total++;
    if (instr_count4 !== 4'd1 || instr_count !== 16'd17) begin
      bad++; $display("FAIL wrap: got cnt4=%0d cnt16=%0d want 1 17", instr_count4, instr_count);
    end
  endtask

  task automatic test_random();
    repeat (40) run_instr(4'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  initial begin
    test_reset();
    test_rtype_lw();
    test_sw_wait();
    test_branches();
    test_illegal();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
